// File: rtl/gen_toggle_detect.sv
// gen_toggle_detect: per-bit toggle-coverage front end for one signal group.
// It samples sig_in on every cycle and detects 0->1 and 1->0 edges on each bit.
// It tracks which bits have seen both edges and keeps a count of covered bits.
// The monitored design is never back-pressured.
//
// Build option TOGGLE_ONESHOT_EN:
//   defined   - valid[i] pulses once, in the cycle after bit i completes.
//   undefined - valid[i] pulses one cycle after every detected edge.
module gen_toggle_detect #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  input  logic             clear,
  output logic [WIDTH-1:0] valid,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  logic [WIDTH-1:0] prev_q;
  logic             primed_q;
  logic [WIDTH-1:0] rise_seen_q, rise_seen_d;
  logic [WIDTH-1:0] fall_seen_q, fall_seen_d;
  logic [WIDTH-1:0] done_q, done_d;
  logic [WIDTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             all_q, all_d;

  logic [WIDTH-1:0] rise, fall, complete;

  // Edge detection is held off until prev holds a real sample, not its reset value.
  always_comb begin
    rise = '0;
    fall = '0;
    if (primed_q) begin
      rise = ~prev_q & sig_in;
      fall = prev_q & ~sig_in;
    end
  end

  // Sticky edge tracking, completion, pulse generation and the covered count.
  always_comb begin
    rise_seen_d = rise_seen_q | rise;
    fall_seen_d = fall_seen_q | fall;
    complete    = (rise_seen_q | rise) & (fall_seen_q | fall) & ~done_q;
    done_d      = done_q | complete;
`ifdef TOGGLE_ONESHOT_EN
    valid_d     = complete;
`else
    valid_d     = rise | fall;
`endif
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d = cnt_d + CNT_W'(done_d[i]);
    end
    all_d = (cnt_d == CNT_W'(WIDTH));
    // Clear drops coverage state, including any edges sampled in this cycle.
    if (clear) begin
      rise_seen_d = '0;
      fall_seen_d = '0;
      done_d      = '0;
      valid_d     = '0;
      cnt_d       = '0;
      all_d       = 1'b0;
    end
  end

  // State registers. The sampler keeps running through clear so that an edge
  // in the cycle after clear is detected.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q      <= '0;
      primed_q    <= 1'b0;
      rise_seen_q <= '0;
      fall_seen_q <= '0;
      done_q      <= '0;
      valid_q     <= '0;
      cnt_q       <= '0;
      all_q       <= 1'b0;
    end else begin
      prev_q      <= sig_in;
      primed_q    <= 1'b1;
      rise_seen_q <= rise_seen_d;
      fall_seen_q <= fall_seen_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      all_q       <= all_d;
    end
  end

  assign valid       = valid_q;
  assign covered_cnt = cnt_q;
  assign all_covered = all_q;

endmodule

// File: tb/tb_gen_toggle_detect.sv
// Testbench for gen_toggle_detect (WIDTH=32). A behavioural model predicts
// the outputs each cycle. The predictions pass through a scoreboard queue.
// Scenario tasks add checks against fixed, hand-derived values.
module tb_gen_toggle_detect;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] sig_in;
  logic        clear;
  logic [31:0] valid;
  logic [5:0]  covered_cnt;
  logic        all_covered;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] v;
    logic [5:0]  c;
    logic        a;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [31:0] m_prev, m_rseen, m_fseen, m_done;
  logic        m_primed;

`ifdef TOGGLE_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  gen_toggle_detect #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .clear       (clear),
    .valid       (valid),
    .covered_cnt (covered_cnt),
    .all_covered (all_covered)
  );

  always #5 clock = ~clock;

  // Drive one cycle of stimulus. Predict the result and push it.
  // Then pop the prediction and compare it after the edge.
  task automatic step(input logic [31:0] s, input logic clr, input logic rst);
    exp_t e;
    logic [31:0] r, f, newly;
    @(negedge clock);
    sig_in = s;
    clear  = clr;
    reset  = rst;
    if (rst) begin
      m_prev = '0; m_primed = 0; m_rseen = '0; m_fseen = '0; m_done = '0;
      e.v = '0; e.c = '0; e.a = 0;
    end else begin
      r = '0; f = '0;
      for (int i = 0; i < 32; i++) begin
        if (m_primed && !m_prev[i] && s[i]) r[i] = 1'b1;
        if (m_primed && m_prev[i] && !s[i]) f[i] = 1'b1;
      end
      if (clr) begin
        m_rseen = '0; m_fseen = '0; m_done = '0;
        e.v = '0; e.c = '0; e.a = 0;
      end else begin
        m_rseen = m_rseen | r;
        m_fseen = m_fseen | f;
        newly   = m_rseen & m_fseen & ~m_done;
        m_done  = m_done | newly;
        e.v = ONESHOT ? newly : (r | f);
        e.c = 6'($countones(m_done));
        e.a = ($countones(m_done) == 32);
      end
      m_prev = s;
      m_primed = 1;
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: actual queue size 0, required at least 1");
    end else begin
      e = sb.pop_front();
      if (valid !== e.v || covered_cnt !== e.c || all_covered !== e.a)
        $display("FAIL sb_outputs: actual valid=%h cnt=%0d all=%b, required valid=%h cnt=%0d all=%b",
                 valid, covered_cnt, all_covered, e.v, e.c, e.a);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    step(32'h0, 0, 1);
    step(32'h0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(32'h0, 0, 0);
      n_total++;
      if (valid !== 32'h0 || covered_cnt !== 6'd0 || all_covered !== 1'b0)
        $display("FAIL reset_idle: actual valid=%h cnt=%0d all=%b, required 0/0/0",
                 valid, covered_cnt, all_covered);
      else n_pass++;
    end
  endtask

  task automatic test_primed_all();
    step(32'hFFFF_FFFF, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(32'hFFFF_FFFF, 0, 0);
      n_total++;
      if (valid !== 32'h0)
        $display("FAIL primed_guard: actual valid=%h, required 00000000", valid);
      else n_pass++;
    end
    step(32'h0, 0, 0);
    step(32'h0, 0, 0);
    step(32'h0, 0, 0);
    step(32'hFFFF_FFFF, 0, 0);
    n_total++;
    if (valid !== 32'hFFFF_FFFF || covered_cnt !== 6'd32 || all_covered !== 1'b1)
      $display("FAIL all_complete: actual valid=%h cnt=%0d all=%b, required ffffffff/32/1",
               valid, covered_cnt, all_covered);
    else n_pass++;
    step(32'hFFFF_FFFF, 0, 0);
    n_total++;
    if (valid !== 32'h0 || covered_cnt !== 6'd32)
      $display("FAIL all_after: actual valid=%h cnt=%0d, required 00000000/32", valid, covered_cnt);
    else n_pass++;
  endtask

  task automatic test_single_bit();
    int pulses = 0;
    step(32'h0, 0, 1);
    step(32'h0, 0, 0);
    step(32'h20, 0, 0); if (valid[5]) pulses++;
    step(32'h0,  0, 0); if (valid[5]) pulses++;
    step(32'h20, 0, 0); if (valid[5]) pulses++;
    step(32'h0,  0, 0); if (valid[5]) pulses++;
    step(32'h0,  0, 0); if (valid[5]) pulses++;
    n_total++;
    if (pulses != (ONESHOT ? 1 : 4) || covered_cnt !== 6'd1)
      $display("FAIL bit5_pulses: actual pulses=%0d cnt=%0d, required pulses=%0d cnt=1",
               pulses, covered_cnt, ONESHOT ? 1 : 4);
    else n_pass++;
  endtask

  task automatic test_clear();
    step(32'h0, 0, 1);
    step(32'h0, 0, 0);
    step(32'h8, 0, 0);
    step(32'h0, 1, 0);
    n_total++;
    if (valid[3] !== 1'b0 || covered_cnt !== 6'd0)
      $display("FAIL clear_discard: actual valid3=%b cnt=%0d, required 0/0", valid[3], covered_cnt);
    else n_pass++;
    step(32'h0, 0, 0);
    step(32'h8, 0, 0);
    step(32'h0, 0, 0);
    n_total++;
    if (valid[3] !== 1'b1 || covered_cnt !== 6'd1)
      $display("FAIL clear_recover: actual valid3=%b cnt=%0d, required 1/1", valid[3], covered_cnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    step(32'h0, 0, 1);
    step(32'h0, 0, 0);
    step(32'h0000_FFFF, 0, 0);
    step(32'h0, 0, 0);
    n_total++;
    if (covered_cnt !== 6'd16)
      $display("FAIL half_cnt: actual cnt=%0d, required 16", covered_cnt);
    else n_pass++;
    step(32'h0, 0, 1);
    n_total++;
    if (covered_cnt !== 6'd0 || valid !== 32'h0)
      $display("FAIL mid_reset: actual cnt=%0d valid=%h, required 0/00000000", covered_cnt, valid);
    else n_pass++;
    step(32'h0000_FFFF, 0, 0);
    n_total++;
    if (valid !== 32'h0)
      $display("FAIL post_reset_sample: actual valid=%h, required 00000000", valid);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    step(32'h0, 0, 1);
    step(32'h0, 0, 0);
    step(32'h8000_0001, 0, 0);
    step(32'h0, 0, 0);
    n_total++;
    if (valid !== 32'h8000_0001 || covered_cnt !== 6'd2)
      $display("FAIL simul_complete: actual valid=%h cnt=%0d, required 80000001/2", valid, covered_cnt);
    else n_pass++;
    step(32'h0, 0, 0);
    n_total++;
    if (valid !== 32'h0)
      $display("FAIL simul_single: actual valid=%h, required 00000000", valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] cur = '0;
    step(32'h0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      cur = cur ^ ($urandom & $urandom & $urandom);
      step(cur, ($urandom_range(0, 29) == 0), ($urandom_range(0, 79) == 0));
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; sig_in = '0;
    m_prev = '0; m_primed = 0; m_rseen = '0; m_fseen = '0; m_done = '0;
    test_reset();
    test_primed_all();
    test_single_bit();
    test_clear();
    test_mid_reset();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
